// File: rtl/tx_msg_scheduler_if.sv
// Issue/completion channel between the message scheduler and the TX FSM.
interface tx_msg_scheduler_if #(
  parameter int unsigned NUM_MSGS   = 4,
  parameter int unsigned ADDR_WIDTH = 9
);
  localparam int unsigned ID_W = $clog2(NUM_MSGS);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [ID_W-1:0]       tx_msg_id;
  logic [ADDR_WIDTH-1:0] tx_start_addr;
  logic                  tx_done;
  logic                  tx_abort;

  modport master (
    output tx_valid, tx_msg_id, tx_start_addr, tx_abort,
    input  tx_ready, tx_done
  );

  modport slave (
    input  tx_valid, tx_msg_id, tx_start_addr, tx_abort,
    output tx_ready, tx_done
  );
endinterface

// File: rtl/tx_msg_scheduler.sv
// Round-robin packet send scheduler: queues per-message triggers, issues one
// message at a time to the TX FSM and aborts sends that stall past TIMEOUT.
module tx_msg_scheduler #(
  parameter int unsigned NUM_MSGS   = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MSGS-1:0]            trigger_send,
  input  logic [NUM_MSGS*ADDR_WIDTH-1:0] pkt_start_addr,
  tx_msg_scheduler_if.master             tx,
  output logic [NUM_MSGS-1:0]            pending,
  output logic [NUM_MSGS-1:0]            done_status,
  input  logic [NUM_MSGS-1:0]            done_clear,
  output logic                           busy,
  output logic                           err_retrigger,
  output logic                           err_timeout
);

  localparam int unsigned ID_W  = $clog2(NUM_MSGS);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic [TMR_W-1:0]      timer;

  logic [ID_W-1:0]       sel_c;
  logic [ID_W-1:0]       idx_c;
  logic                  found_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic                  accept_c;
  logic [NUM_MSGS-1:0]   accept_mask_c;
  logic [NUM_MSGS-1:0]   done_set_c;

  // Round-robin pick: first pending bit after last_grant, wrapping.
  always_comb begin
    sel_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_MSGS; i++) begin
      idx_c = last_grant + ID_W'(i);
      if (!found_c && pending[idx_c]) begin
        sel_c   = idx_c;
        found_c = 1'b1;
      end
    end
    sel_addr_c = pkt_start_addr[sel_c*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    accept_c      = (state == ISSUE) && tx.tx_valid && tx.tx_ready;
    accept_mask_c = accept_c ? (NUM_MSGS'(1) << tx.tx_msg_id) : '0;
    done_set_c    = ((state == WAIT_DONE) && tx.tx_done) ?
                    (NUM_MSGS'(1) << tx.tx_msg_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= ID_W'(NUM_MSGS - 1);
      timer            <= '0;
      pending          <= '0;
      done_status      <= '0;
      busy             <= 1'b0;
      err_retrigger    <= 1'b0;
      err_timeout      <= 1'b0;
      tx.tx_valid      <= 1'b0;
      tx.tx_msg_id     <= '0;
      tx.tx_start_addr <= '0;
      tx.tx_abort      <= 1'b0;
    end else begin
      // A trigger landing on the message being accepted re-queues it.
      pending       <= (pending & ~accept_mask_c) | trigger_send;
      err_retrigger <= |(trigger_send & pending & ~accept_mask_c);
      done_status   <= (done_status & ~done_clear) | done_set_c;
      tx.tx_abort   <= 1'b0;
      err_timeout   <= 1'b0;

      case (state)
        IDLE: begin
          if (found_c) begin
            tx.tx_msg_id     <= sel_c;
            tx.tx_start_addr <= sel_addr_c;
            tx.tx_valid      <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end

        ISSUE: begin
          if (accept_c) begin
            tx.tx_valid <= 1'b0;
            last_grant  <= tx.tx_msg_id;
            timer       <= '0;
            state       <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (tx.tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            tx.tx_abort <= 1'b1;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          tx.tx_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_msg_scheduler.sv
// Directed bench for tx_msg_scheduler with an issue-order scoreboard.
module tb_tx_msg_scheduler;

  localparam int unsigned NUM_MSGS   = 4;
  localparam int unsigned ADDR_WIDTH = 9;
  localparam int unsigned TIMEOUT    = 16;

  typedef struct {
    logic [1:0] id;
    logic [8:0] addr;
  } issue_t;

  logic                           clk;
  logic                           rst;
  logic [NUM_MSGS-1:0]            trigger_send;
  logic [NUM_MSGS*ADDR_WIDTH-1:0] pkt_start_addr;
  logic [NUM_MSGS-1:0]            pending;
  logic [NUM_MSGS-1:0]            done_status;
  logic [NUM_MSGS-1:0]            done_clear;
  logic                           busy;
  logic                           err_retrigger;
  logic                           err_timeout;

  logic [8:0] cfg [NUM_MSGS];
  issue_t     sb [$];
  int         total = 0;
  int         bad   = 0;

  tx_msg_scheduler_if #(.NUM_MSGS(NUM_MSGS), .ADDR_WIDTH(ADDR_WIDTH)) tx_if ();

  tx_msg_scheduler #(
    .NUM_MSGS  (NUM_MSGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger_send  (trigger_send),
    .pkt_start_addr(pkt_start_addr),
    .tx            (tx_if.master),
    .pending       (pending),
    .done_status   (done_status),
    .done_clear    (done_clear),
    .busy          (busy),
    .err_retrigger (err_retrigger),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "bench hung");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NUM_MSGS; i++)
      pkt_start_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = cfg[i];
  endtask

  task automatic expect_issue(input int id);
    issue_t e;
    e.id   = 2'(id);
    e.addr = cfg[id];
    sb.push_back(e);
  endtask

  task automatic trig(input logic [NUM_MSGS-1:0] t);
    trigger_send = t;
    tick();
    trigger_send = '0;
  endtask

  // Wait (bounded) for tx_valid, then compare the issue against the scoreboard head.
  task automatic wait_issue(input string tag);
    issue_t e;
    int n = 0;
    while (!tx_if.tx_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(tx_if.tx_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_id"},   32'(tx_if.tx_msg_id),     32'(e.id));
      chk({tag, "_addr"}, 32'(tx_if.tx_start_addr), 32'(e.addr));
    end else begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=issue expected=none_queued", tag);
    end
  endtask

  task automatic done_after(input int n);
    repeat (n - 1) tick();
    tx_if.tx_done = 1'b1;
    tick();
    tx_if.tx_done = 1'b0;
  endtask

  task automatic accept_and_done(input int n);
    tick();
    done_after(n);
  endtask

  initial begin
    cfg[0] = 9'h010; cfg[1] = 9'h020; cfg[2] = 9'h040; cfg[3] = 9'h080;
    apply_cfg();
    rst = 1'b1; trigger_send = '0; done_clear = '0;
    tx_if.tx_ready = 1'b1; tx_if.tx_done = 1'b0;
    tick(); tick();
    chk("rst_valid",   32'(tx_if.tx_valid), 32'd0);
    chk("rst_pending", 32'(pending),        32'd0);
    chk("rst_busy",    32'(busy),           32'd0);
    chk("rst_done",    32'(done_status),    32'd0);
    rst = 1'b0;

    // Single send with latency checks
    expect_issue(2);
    trig(4'b0100);
    chk("s_pending", 32'(pending), 32'b0100);
    chk("s_valid_early", 32'(tx_if.tx_valid), 32'd0);
    tick();
    chk("s_latency", 32'(tx_if.tx_valid), 32'd1);
    wait_issue("s");
    chk("s_busy", 32'(busy), 32'd1);
    tick();
    chk("s_pend_clr", 32'(pending), 32'd0);
    chk("s_valid_drop", 32'(tx_if.tx_valid), 32'd0);
    done_after(5);
    chk("s_done", 32'(done_status), 32'b0100);
    chk("s_idle", 32'(busy), 32'd0);

    // Round-robin from reset priority
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) expect_issue(k);
    trig(4'b1111);
    for (int k = 0; k < 4; k++) begin
      wait_issue("rr");
      accept_and_done(3);
    end
    chk("rr_done", 32'(done_status), 32'b1111);
    expect_issue(0);
    trig(4'b0001);
    wait_issue("rr0");
    accept_and_done(2);
    expect_issue(1);
    expect_issue(0);
    trig(4'b0011);
    wait_issue("rr2a");
    accept_and_done(2);
    wait_issue("rr2b");
    accept_and_done(2);

    // Retrigger while stalled; config change after selection is not reflected
    done_clear = 4'b1111; tick(); done_clear = '0;
    chk("clr_done", 32'(done_status), 32'd0);
    tx_if.tx_ready = 1'b0;
    expect_issue(1);
    trig(4'b0010);
    tick();
    cfg[1] = 9'h1AB; apply_cfg();
    chk("rt_pending0", 32'(pending), 32'b0010);
    trig(4'b0010);
    chk("rt_err", 32'(err_retrigger), 32'd1);
    chk("rt_pending", 32'(pending), 32'b0010);
    tick();
    chk("rt_err_pulse", 32'(err_retrigger), 32'd0);
    wait_issue("rt");
    tx_if.tx_ready = 1'b1;
    accept_and_done(2);
    cfg[1] = 9'h020; apply_cfg();
    tick(); tick();
    chk("rt_single", 32'(tx_if.tx_valid), 32'd0);
    chk("rt_pend_end", 32'(pending), 32'd0);

    // Re-queue in flight, plus done_clear colliding with a done set
    done_clear = 4'b1111; tick(); done_clear = '0;
    expect_issue(3);
    trig(4'b1000);
    wait_issue("rq");
    tick();
    trig(4'b1000);
    chk("rq_no_err", 32'(err_retrigger), 32'd0);
    chk("rq_pending", 32'(pending), 32'b1000);
    done_after(1);
    chk("rq_done", 32'(done_status), 32'b1000);
    expect_issue(3);
    wait_issue("rq2");
    tick();
    tick();
    tx_if.tx_done = 1'b1; done_clear = 4'b1000;
    tick();
    tx_if.tx_done = 1'b0; done_clear = '0;
    chk("clr_vs_set", 32'(done_status), 32'b1000);

    // Watchdog abort exactly TIMEOUT cycles after accept
    done_clear = 4'b1111; tick(); done_clear = '0;
    expect_issue(0);
    trig(4'b0001);
    wait_issue("to");
    tick();
    expect_issue(1);
    trig(4'b0010);
    repeat (14) tick();
    chk("to_early", 32'(tx_if.tx_abort), 32'd0);
    tick();
    chk("to_abort", 32'(tx_if.tx_abort), 32'd1);
    chk("to_err",   32'(err_timeout),    32'd1);
    chk("to_nodone", 32'(done_status),   32'd0);
    tick();
    chk("to_pulse", 32'(tx_if.tx_abort), 32'd0);
    chk("to_next", 32'(tx_if.tx_valid), 32'd1);
    wait_issue("to_n");
    accept_and_done(2);

    // tx_done on the timeout cycle wins
    expect_issue(2);
    trig(4'b0100);
    wait_issue("dt");
    tick();
    repeat (15) tick();
    tx_if.tx_done = 1'b1;
    tick();
    tx_if.tx_done = 1'b0;
    chk("dt_noabort", 32'(tx_if.tx_abort), 32'd0);
    chk("dt_noerr",   32'(err_timeout),    32'd0);
    chk("dt_done",    32'(done_status[2]), 32'd1);

    // Reset in WAIT_DONE drops everything
    expect_issue(0);
    trig(4'b0001);
    wait_issue("rs");
    tick();
    trig(4'b0010);
    rst = 1'b1;
    tick();
    chk("rs_valid",   32'(tx_if.tx_valid),      32'd0);
    chk("rs_busy",    32'(busy),                32'd0);
    chk("rs_pending", 32'(pending),             32'd0);
    chk("rs_done",    32'(done_status),         32'd0);
    chk("rs_abort",   32'(tx_if.tx_abort),      32'd0);
    chk("rs_id",      32'(tx_if.tx_msg_id),     32'd0);
    chk("rs_addr",    32'(tx_if.tx_start_addr), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("rs_quiet", 32'(tx_if.tx_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_msg_scheduler.md
Name: tx_msg_scheduler

Overview:
- Sequences packet transmission for the endpoint.
- Collects per-message send triggers from the host register map into a pending set and selects one round-robin.
- Hands the selected message ID and its configured start address to the TX FSM over a valid/ready handshake, then waits for completion.
- A watchdog aborts stalled sends, so one message cannot hold the TX cache/switch path forever.

Parameters:
- NUM_MSGS, 4, number of message-table entries; must be a power of two, ≥2.
- ADDR_WIDTH, 9, width of a TX cache byte address.
- TIMEOUT, 1024, cycles allowed between handshake acceptance and tx_done before abort; ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- trigger_send  input  NUM_MSGS  one-hot-or-multi pulse; bit i requests a send of message i.
- pkt_start_addr  input  NUM_MSGS*ADDR_WIDTH  per-message start address in the TX cache (configuration).
- tx_valid  output  1  issue request to the TX FSM.
- tx_ready  input  1  TX FSM accepts the issue.
- tx_msg_id  output  log2(NUM_MSGS)  message being issued or in flight.
- tx_start_addr  output  ADDR_WIDTH  start address latched for tx_msg_id.
- tx_done  input  1  pulse: the in-flight message has fully left.
- tx_abort  output  1  one-cycle pulse on watchdog expiry.
- pending  output  NUM_MSGS  queued, not-yet-accepted requests.
- done_status  output  NUM_MSGS  sticky: message i completed since last clear.
- done_clear  input  NUM_MSGS  clears the matching done_status bits.
- busy  output  1  high whenever the state is not IDLE.
- err_retrigger  output  1  one-cycle pulse: trigger hit an already-pending message.
- err_timeout  output  1  one-cycle pulse, coincident with tx_abort.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; all outputs 0; last_grant=NUM_MSGS-1, so message 0 has first priority. Reset mid-transfer drops all pending work without pulsing tx_abort.
- Pending set update, every cycle: pending_next = (pending & ~accepted_clear) | trigger_send.
- Same-cycle trigger and acceptance for message i: pending[i] ends at 1 (a new request is queued).
- err_retrigger pulses the cycle after trigger_send[i] arrives while pending[i] is already 1. pending stays 1; there is no duplicate queueing.
- A trigger for the message currently in WAIT_DONE is legal and re-queues it.
- State IDLE:
  - If pending is nonzero, select the first set bit scanning from last_grant+1, wrapping modulo NUM_MSGS.
  - Register sel in tx_msg_id and pkt_start_addr[sel] in tx_start_addr, then go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - tx_valid=1; tx_msg_id and tx_start_addr are held stable. Config writes to pkt_start_addr after selection are not reflected.
  - On tx_valid&&tx_ready: clear pending[sel], set last_grant=sel, set timer=0, go to WAIT_DONE.
  - tx_valid drops in the cycle after acceptance.
- State WAIT_DONE:
  - timer increments by 1 each cycle.
  - On tx_done: set done_status[sel], go to IDLE.
  - On timer==TIMEOUT-1 without tx_done: pulse tx_abort and err_timeout for 1 cycle, go to IDLE; done_status is not set.
  - tx_done and timeout in the same cycle: done wins, no abort.
  - tx_done seen in IDLE or ISSUE is ignored.
- done_status: done_clear[i] clears bit i. If done_clear[i] coincides with a set of bit i, the set wins.
- Latency: trigger at edge t → pending at t+1 → tx_valid at t+2 (when IDLE and no other request is pending). The minimum gap between consecutive issues is 2 cycles after tx_done (IDLE→ISSUE).
- Timer width: clog2(TIMEOUT); the timer does not wrap, because the abort leaves WAIT_DONE first.

Test Plan:
- Single send: trigger_send=4'b0100, pkt_start_addr[2]=9'h040, tx_ready tied 1, tx_done 5 cycles after accept → tx_valid 2 cycles after trigger with tx_msg_id=2 and tx_start_addr=9'h040; pending[2] clears on accept; done_status=4'b0100; busy returns to 0.
- Round-robin: trigger 4'b1111 at once, each done 3 cycles after accept → issue order 0,1,2,3. Then trigger 4'b0011 after message 0 was last granted → order 1,0.
- Retrigger: trigger message 1, hold tx_ready=0, trigger message 1 again → err_retrigger pulses once; pending=4'b0010; only one issue occurs.
- Re-queue in flight: trigger message 3 during its WAIT_DONE → it is issued again after tx_done; done_status[3] is set.
- Timeout: TIMEOUT=16, accept and never send tx_done → tx_abort and err_timeout pulse exactly 16 cycles after accept; done_status stays 0; the next pending message issues 1 cycle later.
- Edge cases:
  - tx_done on the timeout cycle → no abort.
  - done_clear together with a done set → bit stays 1.
  - rst asserted in WAIT_DONE → all outputs 0 next cycle, pending cleared.
